// File: rtl/clock_ratio_checker_if.sv
// Signal bundle between a divided-clock source/observer and the ratio checker.
// period_valid is a one-cycle pulse with no backpressure: consumers sample period when it is high.
interface clock_ratio_checker_if #(
  parameter int CNT_W = 8
);
  logic             div_in;
  logic [CNT_W-1:0] exp_ratio;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic [7:0]       err_count;
  logic             dbg_state;

  modport master (
    output div_in,
    output exp_ratio,
    input  period,
    input  period_valid,
    input  locked,
    input  err,
    input  err_count,
    input  dbg_state
  );

  modport slave (
    input  div_in,
    input  exp_ratio,
    output period,
    output period_valid,
    output locked,
    output err,
    output err_count,
    output dbg_state
  );
endinterface

// File: rtl/clock_ratio_checker.sv
// Measures the rise-to-rise period of a clk-synchronous divided clock and
// checks it against an expected ratio, reporting lock, errors and timeouts.
module clock_ratio_checker #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  clock_ratio_checker_if.slave   bus
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0]       LOCK_V  = 8'(LOCK_CNT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_div_q;
  logic [CNT_W-1:0] r_exp_q;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_match_run;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_locked;
  logic             r_err;
  logic [7:0]       r_err_count;

  logic             w_rise;
  logic             w_exp_chg;
  logic             w_chk_en;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_run_base;
  logic [7:0]       w_run_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic             w_pv_nxt;
  logic             w_locked_nxt;
  logic             w_err_nxt;
  logic [7:0]       w_err_count_nxt;

  assign w_rise    = bus.div_in & ~r_div_q;
  assign w_exp_chg = (bus.exp_ratio != r_exp_q);
  assign w_chk_en  = (bus.exp_ratio != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_div_q        <= 1'b0;
      r_exp_q        <= '0;
      r_cnt          <= '0;
      r_match_run    <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_err          <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_div_q        <= bus.div_in;
      r_exp_q        <= bus.exp_ratio;
      r_cnt          <= w_cnt_nxt;
      r_match_run    <= w_run_nxt;
      r_period       <= w_period_nxt;
      r_period_valid <= w_pv_nxt;
      r_locked       <= w_locked_nxt;
      r_err          <= w_err_nxt;
      r_err_count    <= w_err_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period;
    w_pv_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
    // An exp_ratio change clears the run before any compare in the same cycle.
    w_run_base   = w_exp_chg ? 8'd0 : r_match_run;
    w_run_nxt    = w_run_base;
    w_locked_nxt = w_exp_chg ? 1'b0 : r_locked;

    if (w_rise) begin
      w_cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_nxt = CNT_MAX;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (r_cnt == CNT_MAX) begin
          // Period too long to measure; a coincident rise simply re-arms.
          w_state_nxt  = w_rise ? ST_MEASURE : ST_IDLE;
          w_run_nxt    = 8'd0;
          w_locked_nxt = 1'b0;
          w_err_nxt    = w_chk_en;
        end else if (w_rise) begin
          w_period_nxt = r_cnt;
          w_pv_nxt     = 1'b1;
          if (w_chk_en) begin
            if (r_cnt == bus.exp_ratio) begin
              w_run_nxt    = (w_run_base >= LOCK_V) ? LOCK_V : 8'(w_run_base + 8'd1);
              w_locked_nxt = (w_run_nxt == LOCK_V);
            end else begin
              w_run_nxt    = 8'd0;
              w_locked_nxt = 1'b0;
              w_err_nxt    = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (!w_chk_en) begin
      w_run_nxt    = 8'd0;
      w_locked_nxt = 1'b0;
    end

    w_err_count_nxt = r_err_count;
    if (w_err_nxt && (r_err_count != 8'hFF)) begin
      w_err_count_nxt = r_err_count + 8'd1;
    end
  end

  assign bus.period       = r_period;
  assign bus.period_valid = r_period_valid;
  assign bus.locked       = r_locked;
  assign bus.err          = r_err;
  assign bus.err_count    = r_err_count;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_clock_ratio_checker.sv
// Randomized bench for clock_ratio_checker against a timestamp-based model of
// divided-clock periods, lock runs and timeouts.
module tb_clock_ratio_checker;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 3;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  clock_ratio_checker_if #(.CNT_W(CNT_W)) bus ();

  clock_ratio_checker #(
    .CNT_W   (CNT_W),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int cur_exp = 0;
  logic [CNT_W-1:0] exp_q[$];

  // Model: rises are timestamped; a period is the distance between rises.
  int m_cyc, m_tr, m_run, m_errcnt, m_period;
  bit m_armed, m_locked, m_pv, m_err, m_prev_d;
  int m_prev_e;

  task automatic check_val(input string tag, input logic [31:0] obs, input int expv);
    total++;
    if (obs !== 32'(expv)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_tr = 0; m_run = 0; m_errcnt = 0; m_period = 0;
    m_armed = 0; m_locked = 0; m_pv = 0; m_err = 0; m_prev_d = 0; m_prev_e = 0;
    exp_q.delete();
  endtask

  task automatic model_cycle(input bit d, input int e);
    bit rise;
    int el;
    rise  = d && !m_prev_d;
    m_pv  = 0;
    m_err = 0;
    if (e != m_prev_e) begin
      m_run = 0; m_locked = 0;
    end
    el = m_cyc - m_tr;
    if (m_armed && el >= MAXC) begin
      if (e != 0) begin
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
      end
      m_run = 0; m_locked = 0;
      m_armed = rise;
      m_tr = m_cyc;
    end else if (m_armed && rise) begin
      m_period = el;
      m_pv = 1;
      exp_q.push_back(CNT_W'(el));
      if (e != 0) begin
        if (el == e) begin
          if (m_run < LOCK_CNT) m_run++;
          m_locked = (m_run == LOCK_CNT);
        end else begin
          m_run = 0; m_locked = 0; m_err = 1;
          if (m_errcnt < 255) m_errcnt++;
        end
      end
      m_tr = m_cyc;
    end else if (rise) begin
      m_armed = 1;
      m_tr = m_cyc;
    end
    if (e == 0) begin
      m_run = 0; m_locked = 0;
    end
    m_prev_d = d;
    m_prev_e = e;
    m_cyc++;
  endtask

  task automatic step(input logic d, input bit rel);
    @(negedge clk);
    if (rel) reset_n = 1'b1;
    bus.div_in    = d;
    bus.exp_ratio = CNT_W'(cur_exp);
    model_cycle(d, cur_exp);
    @(posedge clk);
    #1;
    check_val("period_valid", {31'd0, bus.period_valid}, int'(m_pv));
    check_val("err", {31'd0, bus.err}, int'(m_err));
    check_val("locked", {31'd0, bus.locked}, int'(m_locked));
    check_val("err_count", {24'd0, bus.err_count}, m_errcnt);
    check_val("period", {24'd0, bus.period}, m_period);
    if (bus.period_valid === 1'b1) begin
      check_val("sb_nonempty", {31'd0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) check_val("sb_period", {24'd0, bus.period}, int'(exp_q.pop_front()));
    end
  endtask

  task automatic run_lh(input int lo, input int hi);
    repeat (lo) step(1'b0, 1'b0);
    repeat (hi) step(1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_period"}, {24'd0, bus.period}, 0);
    check_val({tag, "_pv"}, {31'd0, bus.period_valid}, 0);
    check_val({tag, "_locked"}, {31'd0, bus.locked}, 0);
    check_val({tag, "_err"}, {31'd0, bus.err}, 0);
    check_val({tag, "_err_count"}, {24'd0, bus.err_count}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, hi;
    bus.div_in    = 1'b0;
    bus.exp_ratio = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    // Ideal /4 with exp 4: arm, then lock after three periods.
    cur_exp = 4;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (10) run_lh(2, 2);
    check_val("p1_locked", {31'd0, bus.locked}, 1);
    check_val("p1_errs", {24'd0, bus.err_count}, 0);

    // /8 with one stretched period of 9.
    cur_exp = 8;
    repeat (6) run_lh(4, 4);
    run_lh(5, 4);
    repeat (5) run_lh(4, 4);
    check_val("p2_locked", {31'd0, bus.locked}, 1);

    // /2 then stuck low long enough to time out, then restart.
    cur_exp = 2;
    repeat (6) run_lh(1, 1);
    repeat (300) step(1'b0, 1'b0);
    repeat (6) run_lh(1, 1);

    // Checking disabled.
    cur_exp = 0;
    repeat (8) run_lh(2, 2);
    check_val("p4_locked", {31'd0, bus.locked}, 0);

    // Locked on /4, then ratio switched mid-period.
    cur_exp = 4;
    repeat (6) run_lh(2, 2);
    step(1'b0, 1'b0);
    cur_exp = 2;
    step(1'b0, 1'b0);
    check_val("p5_unlock", {31'd0, bus.locked}, 0);
    repeat (3) run_lh(2, 2);

    // Random periods, ratio changes and occasional timeouts.
    repeat (150) begin
      if ($urandom_range(0, 9) == 0) cur_exp = $urandom_range(0, 10);
      lo = $urandom_range(1, 5);
      hi = $urandom_range(1, 5);
      if ($urandom_range(0, 39) == 0) lo = $urandom_range(250, 258);
      if ($urandom_range(0, 2) == 0) lo = (cur_exp > 1) ? cur_exp - hi : lo;
      if (lo < 1) lo = 1;
      run_lh(lo, hi);
    end

    // Asynchronous reset mid-operation.
    cur_exp = 4;
    repeat (6) run_lh(2, 2);
    @(negedge clk);
    reset_n = 1'b0;
    bus.div_in = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (5) run_lh(2, 2);

    check_val("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_ratio_checker.md
Name: clock_ratio_checker

Overview:
- Consumes a divided clock produced from the same `clk` (e.g. the /2, /4 or /8 outputs of the clock divider).
- Measures the rising-edge-to-rising-edge period of that clock in `clk` cycles.
- Compares the period against an expected divide ratio and reports lock, per-period errors and timeouts.
- Sits at the receiving end of divided-clock nets as a self-check / BIST monitor.

Parameters:
- CNT_W, 8, width of period counter, `exp_ratio` and `period`; maximum measurable period is 2^CNT_W-2.
- LOCK_CNT, 3, consecutive matching periods required before `locked` asserts (1..255).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- div_in  input  1  divided clock under test; synchronous to `clk`, no synchronizer.
- exp_ratio  input  CNT_W  expected period in `clk` cycles; 0 disables checking.
- period  output  CNT_W  last measured period.
- period_valid  output  1  one-cycle pulse when `period` updates.
- locked  output  1  LOCK_CNT consecutive periods matched `exp_ratio`.
- err  output  1  one-cycle pulse on mismatch or timeout.
- err_count  output  8  saturating error counter.

Behaviour:
- Reset (async, `reset_n` = 0): all outputs 0, `div_q` = 0, `cnt` = 0, `match_run` = 0, state IDLE.
- Edge detect: `div_q` is `div_in` delayed one `clk`; rise = `div_in` & ~`div_q`. Rise is evaluated in the same cycle `div_in` goes high.
- Counter `cnt`: on rise it loads 1; otherwise it increments, saturating at 2^CNT_W-1.
- State IDLE:
  - counts nothing meaningful;
  - first rise moves to MEASURE (arm only: no `period_valid`, no compare).
- State MEASURE, rise with `cnt` < max:
  - `period` <= `cnt`; `period_valid` = 1 the next cycle.
  - Compare uses the same `cnt` value.
  - Match: `match_run` increments, saturating at LOCK_CNT; `locked` <= 1 when the new `match_run` == LOCK_CNT.
  - Mismatch: `match_run` <= 0, `locked` <= 0, `err` pulse, `err_count` += 1 (saturating at 255).
  - `exp_ratio` == 0: no compare; `locked` = 0, `err` never pulses, `match_run` held at 0.
- Timeout, MEASURE with `cnt` reaching 2^CNT_W-1 and no rise:
  - state -> IDLE, `locked` <= 0, `match_run` <= 0;
  - one `err` pulse and `err_count` += 1 (unless `exp_ratio` == 0);
  - no `period_valid`;
  - the next rise re-arms only.
- Latency: `period` / `period_valid` / `err` / `locked` appear one `clk` after the cycle the rise is detected. Example: a /2 stream gives period = 2.
- `exp_ratio` change (value differs from the previous cycle): `match_run` <= 0 and `locked` <= 0 the next cycle, with no `err`. Measurement continues and the period in flight is compared against the new value.
- Simultaneous rise and `exp_ratio` change: the change clears first, and a matching period then sets `match_run` = 1.
- Reset mid-operation: immediate return to reset values, including `err_count`.
- `err` and `period_valid` may assert in the same cycle (mismatch).

Test Plan:
1. `exp_ratio`=4, `div_in` = ideal /4 (2 low, 2 high) after reset release -> first rise arms only; `period_valid` pulses every 4 cycles with `period`=4; `locked`=1 one cycle after the 3rd valid period; `err_count`=0.
2. `exp_ratio`=8, /8 stream with one stretched period of 9 cycles after lock -> that period reports `period`=9, `err` pulse, `locked` drops, `err_count`=1. `locked` returns after 3 more periods of 8.
3. Locked on /2, then `div_in` stuck low -> 255 cycles after the last rise (CNT_W=8), `err` pulse, `locked`=0, `err_count` +1. Restarting /2 needs 1 arm rise + 3 periods to relock.
4. `exp_ratio`=0 with a /4 stream -> `period`=4 and `period_valid` pulses, `locked`=0, `err` never asserts.
5. Locked on /4, `exp_ratio` switched to 2 -> `locked`=0 next cycle without `err`. The next period (4) mismatches: `err`, `err_count`=1.
6. `reset_n` asserted for 1 cycle mid-lock with `err_count`=2 -> all outputs 0 immediately (async). The first post-reset rise produces no `period_valid`.
